// File: rtl/gemm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_ctrl_pkg
//  Description : Shared state codes for the GEMM tile sequencing path. The
//                numeric codes match the decode inside systolic_array_top.
//  Revision    : 1.0 - initial release
// ============================================================================
package gemm_ctrl_pkg;

  // Array control codes; the array decodes these values directly
  localparam int unsigned IDLE   = 0;
  localparam int unsigned WARMUP = 1;
  localparam int unsigned STEADY = 2;
  localparam int unsigned DRAIN  = 3;

  // Controller FSM states, encoded with the array codes so the state
  // register can drive o_ctrl_state without a translation table
  typedef enum logic [1:0] {
    ST_IDLE   = 2'(IDLE),
    ST_WARMUP = 2'(WARMUP),
    ST_STEADY = 2'(STEADY),
    ST_DRAIN  = 2'(DRAIN)
  } ctrl_state_e;

endpackage : gemm_ctrl_pkg
`default_nettype wire

// File: rtl/gemm_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_tile_ctrl
//  Description : Sequences one output-stationary GEMM tile on the systolic
//                array: latches the SRAM read windows on start, walks the
//                array through WARMUP / STEADY / DRAIN using a single
//                down-counter, then pulses done. Rejected configs pulse err.
//  Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_ctrl
  import gemm_ctrl_pkg::*;
#(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_end_addr,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int AW    = LOG2_SRAM_BANK_DEPTH;
  // One extra bit so a full-depth window (L = 2^AW) still fits the counter
  localparam int CNT_W = AW + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WARM_LEN  = CNT_W'(NUM_ROW);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(NUM_ROW + NUM_COL - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [AW-1:0] top_start_q,  top_start_d;
  logic [AW-1:0] top_end_q,    top_end_d;
  logic [AW-1:0] left_start_q, left_start_d;
  logic [AW-1:0] left_end_q,   left_end_d;
  logic [AW-1:0] down_start_q, down_start_d;
  logic [AW-1:0] down_end_q,   down_end_d;

  logic             cfg_ok;
  logic [CNT_W-1:0] steady_len;

  // A start is only legal when the top and left windows are non-empty;
  // the down window is written by the array and is not range-checked
  assign cfg_ok = (i_top_end_addr >= i_top_start_addr) &&
                  (i_left_end_addr >= i_left_start_addr);

  // STEADY length from the latched left window, widened before subtracting
  assign steady_len = {1'b0, left_end_q} - {1'b0, left_start_q} + CNT_ONE;

  // Next-state, counter reload and pulse generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    top_start_d  = top_start_q;
    top_end_d    = top_end_q;
    left_start_d = left_start_q;
    left_end_d   = left_end_q;
    down_start_d = down_start_q;
    down_end_d   = down_end_q;

    case (state_q)
      ST_IDLE: begin
        // Abort in IDLE swallows a simultaneous start
        if (i_start && !i_abort) begin
          if (cfg_ok) begin
            state_d      = ST_WARMUP;
            cnt_d        = WARM_LEN;
            top_start_d  = i_top_start_addr;
            top_end_d    = i_top_end_addr;
            left_start_d = i_left_start_addr;
            left_end_d   = i_left_end_addr;
            down_start_d = i_down_start_addr;
            down_end_d   = i_down_end_addr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WARMUP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_STEADY;
          cnt_d   = steady_len;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STEADY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LEN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort beats any terminal transition of the active phase
    if ((state_q != ST_IDLE) && i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Busy is registered alongside the state so every output comes from a flop
  assign busy_d = (state_d != ST_IDLE);

  // Control state, counter and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Latched address windows; they only change on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_start_q  <= '0;
      top_end_q    <= '0;
      left_start_q <= '0;
      left_end_q   <= '0;
      down_start_q <= '0;
      down_end_q   <= '0;
    end else begin
      top_start_q  <= top_start_d;
      top_end_q    <= top_end_d;
      left_start_q <= left_start_d;
      left_end_q   <= left_end_d;
      down_start_q <= down_start_d;
      down_end_q   <= down_end_d;
    end
  end

  assign o_ctrl_state              = CTRL_WIDTH'(state_q);
  assign o_busy                    = busy_q;
  assign o_done                    = done_q;
  assign o_err                     = err_q;
  assign o_top_sram_rd_start_addr  = top_start_q;
  assign o_top_sram_rd_end_addr    = top_end_q;
  assign o_left_sram_rd_start_addr = left_start_q;
  assign o_left_sram_rd_end_addr   = left_end_q;
  assign o_down_sram_rd_start_addr = down_start_q;
  assign o_down_sram_rd_end_addr   = down_end_q;

endmodule : gemm_tile_ctrl
`default_nettype wire

// File: tb/tb_gemm_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gemm_tile_ctrl
//  Description : Self-checking bench for gemm_tile_ctrl. A schedule-queue
//                reference model is compared every cycle; a scenario table
//                and hand sequences cover the named corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_ctrl;
  import gemm_ctrl_pkg::*;

  localparam int NUM_ROW    = 4;
  localparam int NUM_COL    = 4;
  localparam int AW         = 5;
  localparam int CTRL_WIDTH = 4;
  localparam int VW         = CTRL_WIDTH + 3 + 6 * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [AW-1:0] i_top_start_addr = '0, i_top_end_addr = '0;
  logic [AW-1:0] i_left_start_addr = '0, i_left_end_addr = '0;
  logic [AW-1:0] i_down_start_addr = '0, i_down_end_addr = '0;
  logic [CTRL_WIDTH-1:0] o_ctrl_state;
  logic [AW-1:0] o_top_s, o_top_e, o_left_s, o_left_e, o_down_s, o_down_e;
  logic          o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gemm_tile_ctrl #(
    .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL),
    .LOG2_SRAM_BANK_DEPTH(AW), .CTRL_WIDTH(CTRL_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_top_start_addr(i_top_start_addr), .i_top_end_addr(i_top_end_addr),
    .i_left_start_addr(i_left_start_addr), .i_left_end_addr(i_left_end_addr),
    .i_down_start_addr(i_down_start_addr), .i_down_end_addr(i_down_end_addr),
    .o_ctrl_state(o_ctrl_state),
    .o_top_sram_rd_start_addr(o_top_s), .o_top_sram_rd_end_addr(o_top_e),
    .o_left_sram_rd_start_addr(o_left_s), .o_left_sram_rd_end_addr(o_left_e),
    .o_down_sram_rd_start_addr(o_down_s), .o_down_sram_rd_end_addr(o_down_e),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {o_ctrl_state, o_busy, o_done, o_err,
                    o_top_s, o_top_e, o_left_s, o_left_e, o_down_s, o_down_e};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model: queue of upcoming per-cycle states ----
  logic [1:0]    m_sched[$];
  logic          m_done = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_ts = '0, m_te = '0, m_ls = '0, m_le = '0, m_ds = '0, m_de = '0;
  bit            mdl_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sched.delete();
      m_done = 1'b0; m_err = 1'b0;
      m_ts = '0; m_te = '0; m_ls = '0; m_le = '0; m_ds = '0; m_de = '0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_sched.size() != 0) begin
        if (i_abort) m_sched.delete();
        else begin
          void'(m_sched.pop_front());
          if (m_sched.size() == 0) m_done = 1'b1;
        end
      end else if (i_start && !i_abort) begin
        if (i_top_end_addr < i_top_start_addr || i_left_end_addr < i_left_start_addr)
          m_err = 1'b1;
        else begin
          int len;
          m_ts = i_top_start_addr;  m_te = i_top_end_addr;
          m_ls = i_left_start_addr; m_le = i_left_end_addr;
          m_ds = i_down_start_addr; m_de = i_down_end_addr;
          len = int'(i_left_end_addr) - int'(i_left_start_addr) + 1;
          for (int i = 0; i < NUM_ROW; i++) m_sched.push_back(2'(WARMUP));
          for (int i = 0; i < len; i++) m_sched.push_back(2'(STEADY));
          for (int i = 0; i < NUM_ROW + NUM_COL - 1; i++) m_sched.push_back(2'(DRAIN));
        end
      end
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [CTRL_WIDTH-1:0] st;
    st = (m_sched.size() != 0) ? CTRL_WIDTH'(m_sched[0]) : '0;
    return {st, (m_sched.size() != 0), m_done, m_err,
            m_ts, m_te, m_ls, m_le, m_ds, m_de};
  endfunction

  always @(negedge clk) begin
    if (mdl_en) check("model_cmp", 64'(dut_vec), 64'(exp_vec()));
  end

  // ---------------- scenario table ----------------------------------------
  typedef struct {
    logic [AW-1:0] ts, te, ls, le, ds, de;
    int abort_at;    // cycle during which abort is held, -1 for none
    int exp_busy;    // cycles with o_busy high
    int exp_done_at; // cycle of the done pulse, -1 for none
    int exp_err;     // number of err pulses
  } vec_t;

  vec_t tbl[7];
  logic [AW-1:0] lat_ts = '0, lat_te = '0, lat_ls = '0, lat_le = '0, lat_ds = '0, lat_de = '0;

  task automatic run_entry(input int idx, input vec_t v);
    int busy_n, done_n, err_n, done_at;
    busy_n = 0; done_n = 0; err_n = 0; done_at = -1;
    @(negedge clk);
    i_top_start_addr = v.ts;  i_top_end_addr = v.te;
    i_left_start_addr = v.ls; i_left_end_addr = v.le;
    i_down_start_addr = v.ds; i_down_end_addr = v.de;
    i_start = 1'b1; i_abort = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy) busy_n++;
      if (o_done) begin done_n++; if (done_at < 0) done_at = k; end
      if (o_err) err_n++;
      i_abort = (k == v.abort_at);
    end
    i_abort = 1'b0;
    if (v.exp_err == 0) begin
      lat_ts = v.ts; lat_te = v.te; lat_ls = v.ls;
      lat_le = v.le; lat_ds = v.ds; lat_de = v.de;
    end
    check($sformatf("vec%0d_busy", idx), 64'(busy_n), 64'(v.exp_busy));
    check($sformatf("vec%0d_done_at", idx), 64'(done_at), 64'(v.exp_done_at));
    check($sformatf("vec%0d_done_cnt", idx), 64'(done_n), 64'((v.exp_done_at >= 0) ? 1 : 0));
    check($sformatf("vec%0d_err_cnt", idx), 64'(err_n), 64'(v.exp_err));
    check($sformatf("vec%0d_addr", idx),
          64'({o_top_s, o_top_e, o_left_s, o_left_e, o_down_s, o_down_e}),
          64'({lat_ts, lat_te, lat_ls, lat_le, lat_ds, lat_de}));
  endtask

  task automatic rand_window(output logic [AW-1:0] s, output logic [AW-1:0] e);
    int a, b;
    a = int'($urandom_range(0, 31));
    if ($urandom_range(0, 4) != 0) b = a + int'($urandom_range(0, 31 - a));
    else b = int'($urandom_range(0, 31));
    s = AW'(a);
    e = AW'(b);
  endtask

  initial begin
    int dones, quiet;
    bit prev_done;

    tbl[0] = '{5'd0, 5'd8,  5'd0, 5'd3,  5'd2,  5'd9,  -1, 15, 16, 0};
    tbl[1] = '{5'd1, 5'd1,  5'd7, 5'd7,  5'd0,  5'd0,  -1, 12, 13, 0};
    tbl[2] = '{5'd3, 5'd4,  5'd5, 5'd2,  5'd6,  5'd7,  -1,  0, -1, 1};
    tbl[3] = '{5'd9, 5'd3,  5'd1, 5'd2,  5'd1,  5'd1,  -1,  0, -1, 1};
    tbl[4] = '{5'd4, 5'd20, 5'd0, 5'd5,  5'd3,  5'd3,   6,  6, -1, 0};
    tbl[5] = '{5'd2, 5'd30, 5'd0, 5'd31, 5'd10, 5'd31, -1, 43, 44, 0};
    tbl[6] = '{5'd0, 5'd31, 5'd3, 5'd10, 5'd31, 5'd0,  -1, 19, 20, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dut_vec), 64'(0));
    rst_n = 1'b1;
    mdl_en = 1'b1;

    for (int i = 0; i < 7; i++) run_entry(i, tbl[i]);

    // Start held high: back-to-back runs, WARMUP right after each done
    @(negedge clk);
    i_top_start_addr = 5'd0; i_top_end_addr = 5'd3;
    i_left_start_addr = 5'd0; i_left_end_addr = 5'd1;
    i_down_start_addr = 5'd1; i_down_end_addr = 5'd2;
    i_start = 1'b1;
    dones = 0; prev_done = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (prev_done) check("b2b_rewarm", 64'(o_ctrl_state), 64'(WARMUP));
      prev_done = o_done;
      if (o_done) dones++;
    end
    check("b2b_done_cnt", 64'(dones), 64'(3));
    i_start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset asserted in DRAIN: outputs clear at once, nothing follows release
    @(negedge clk);
    i_top_start_addr = 5'd0; i_top_end_addr = 5'd8;
    i_left_start_addr = 5'd0; i_left_end_addr = 5'd3;
    i_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    check("pre_reset_drain", 64'(o_ctrl_state), 64'(DRAIN));
    #2 rst_n = 1'b0;
    #1 check("reset_async", 64'(dut_vec), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_busy || o_done || o_err) quiet++;
    end
    check("post_reset_quiet", 64'(quiet), 64'(0));

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      i_start = ($urandom_range(0, 3) == 0);
      i_abort = ($urandom_range(0, 29) == 0);
      rand_window(i_top_start_addr, i_top_end_addr);
      rand_window(i_left_start_addr, i_left_end_addr);
      i_down_start_addr = AW'($urandom_range(0, 31));
      i_down_end_addr   = AW'($urandom_range(0, 31));
    end
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gemm_tile_ctrl
`default_nettype wire
